// File: rtl/divider_four_bit.sv
`timescale 1ns/1ps
// divider_four_bit: sequential unsigned restoring divider.
// Operands are latched on start. One quotient bit is resolved per clock, and
// the results are published with a one-cycle done strobe. A zero divisor
// short-circuits to an all-ones quotient with div_by_zero set.
module divider_four_bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_work;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_work;   // latched divisor
    logic [WIDTH:0]   r_work;   // partial remainder
    logic [CNT_W-1:0] step;     // completed RUN steps

    logic [WIDTH+1:0] diff;
    logic             fits;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try to subtract the divisor; the borrow decides.
    // The partial remainder always stays below the divisor, so its top bit is
    // zero and the full-width minuend equals {0, S}.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        diff   = {r_work, q_work[WIDTH-1]} - {2'b00, d_work};
        fits   = ~diff[WIDTH+1];
        r_next = fits ? diff[WIDTH:0] : {r_work[WIDTH-1:0], q_work[WIDTH-1]};
        q_next = {q_work[WIDTH-2:0], fits};
    end

    // Control FSM, working registers and registered result outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: working registers are reset too, so no X ever reaches the step logic.
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q_work      <= '0;
            d_work      <= '0;
            r_work      <= '0;
            step        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_work <= dividend;
                        d_work <= divisor;
                        r_work <= '0;
                        step   <= '0;
                        if (divisor != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_work <= q_next;
                    r_work <= r_next;
                    step   <= step + CNT_W'(1);
                    if (step == CNT_W'(WIDTH - 1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= r_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
